branch_predictor: RTL

- Fetch-stage branch predictor: a direct-mapped BTB with a 2-bit saturating-counter BHT.
- Same-cycle lookup by fetch PC; produces the predicted next PC.
- Updated from EX with the resolved outcome from the branch comparator (`taken`) and the computed target.
- Sits upstream of IF's PC mux; closes the loop with the EX-stage branch compare.

---
 rtl/branch_predictor.sv | 137 +++++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped BTB with 2-bit saturating counters.
// Define BP_STATS_EN to add the stat_updates / stat_mispreds event counters.
module branch_predictor #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 64,
    localparam int IDXW   = $clog2(ENTRIES)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_pc,
    input  logic            upd_en,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_uncond,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
`ifdef BP_STATS_EN
    output logic [31:0]     stat_updates,
    output logic [31:0]     stat_mispreds,
`endif
    input  logic            upd_mispred
);

    localparam int TAGW = XLEN - IDXW - 2;

    logic            valid_q  [ENTRIES];
    logic [TAGW-1:0] tag_q    [ENTRIES];
    logic [XLEN-1:0] target_q [ENTRIES];
    logic [1:0]      ctr_q    [ENTRIES];

    logic            valid_d  [ENTRIES];
    logic [TAGW-1:0] tag_d    [ENTRIES];
    logic [XLEN-1:0] target_d [ENTRIES];
    logic [1:0]      ctr_d    [ENTRIES];

    logic [IDXW-1:0] if_idx;
    logic [TAGW-1:0] if_tag;
    logic            if_hit;
    logic [IDXW-1:0] upd_idx;
    logic [TAGW-1:0] upd_tag;
    logic            upd_hit;

    // Low PC bits are always zero for aligned instructions and play no role.
    logic unused_bits;
    assign unused_bits = ^{if_pc[1:0], upd_pc[1:0], upd_mispred};

    assign if_idx  = if_pc[IDXW+1:2];
    assign if_tag  = if_pc[XLEN-1:IDXW+2];
    assign upd_idx = upd_pc[IDXW+1:2];
    assign upd_tag = upd_pc[XLEN-1:IDXW+2];

    assign if_hit  = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    // Lookup always sees the pre-update state; there is no bypass from EX.
    always_comb begin
        pred_taken = if_hit && ctr_q[if_idx][1];
        pred_pc    = pred_taken ? target_q[if_idx] : if_pc + XLEN'(4);
    end

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (upd_en) begin
            if (upd_hit) begin
                if (upd_uncond) begin
                    ctr_d[upd_idx]    = 2'd3;
                    target_d[upd_idx] = upd_target;
                end else if (upd_taken) begin
                    if (ctr_q[upd_idx] != 2'd3) begin
                        ctr_d[upd_idx] = ctr_q[upd_idx] + 2'd1;
                    end
                    target_d[upd_idx] = upd_target;
                end else if (ctr_q[upd_idx] != 2'd0) begin
                    ctr_d[upd_idx] = ctr_q[upd_idx] - 2'd1;
                end
            end else if (upd_taken) begin
                // Allocation replaces whatever aliased into this slot.
                valid_d[upd_idx]  = 1'b1;
                tag_d[upd_idx]    = upd_tag;
                target_d[upd_idx] = upd_target;
                ctr_d[upd_idx]    = upd_uncond ? 2'd3 : 2'd2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'd1;
            end
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            ctr_q    <= ctr_d;
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] stat_updates_q;
    logic [31:0] stat_mispreds_q;
    logic [31:0] stat_updates_d;
    logic [31:0] stat_mispreds_d;

    always_comb begin
        stat_updates_d  = stat_updates_q;
        stat_mispreds_d = stat_mispreds_q;
        if (upd_en) begin
            stat_updates_d = stat_updates_q + 32'd1;
            if (upd_mispred) begin
                stat_mispreds_d = stat_mispreds_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_updates_q  <= '0;
            stat_mispreds_q <= '0;
        end else begin
            stat_updates_q  <= stat_updates_d;
            stat_mispreds_q <= stat_mispreds_d;
        end
    end

    assign stat_updates  = stat_updates_q;
    assign stat_mispreds = stat_mispreds_q;
`endif

endmodule
